// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stage enables/flushes, EX operand
// forwarding, load-use stalls, mispredict recovery FSM and saturating event counters.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned IMEM_LAT   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  input  logic                  i_ex_rd_wren,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
  input  logic                  i_mem_rd_wren,
  input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
  input  logic                  i_wb_rd_wren,
  input  logic                  i_ex_mispredict,
  input  logic                  i_dmem_ready,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_en,
  output logic                  o_id_ex_flush,
  output logic                  o_ex_mem_en,
  output logic                  o_mem_wb_en,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic [1:0]            o_state,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StFlush   = 2'd2,
    StMemWait = 2'd3
  } state_e;

  localparam logic [1:0] LatCd = 2'(IMEM_LAT);

  state_e           state_q, state_d;
  logic [1:0]       cd_q, cd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flushing;
  logic             lu;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic [REG_ADDR_W-1:0] mem_rd,
                                         input logic                  mem_wren,
                                         input logic [REG_ADDR_W-1:0] wb_rd,
                                         input logic                  wb_wren);
    if (mem_wren && (mem_rd != '0) && (mem_rd == rs)) begin
      return 2'b01;
    end else if (wb_wren && (wb_rd != '0) && (wb_rd == rs)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A held countdown in MEM_WAIT means the freeze interrupted a recovery; resume it.
  assign flushing = ((state_q == StFlush) || (state_q == StMemWait)) && (cd_q != 2'd0);

  // ID holds a bubble while flushing, so a match there is not a real hazard.
  assign lu = i_ex_is_load && i_ex_rd_wren && (i_ex_rd_addr != '0) && !flushing &&
              ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
               (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StRun;
      cd_q        <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cd_d        = cd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!i_dmem_ready) begin
      state_d = StMemWait;
    end else if (i_ex_mispredict) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
      if (IMEM_LAT > 0) begin
        cd_d    = LatCd;
        state_d = StFlush;
      end else begin
        cd_d    = 2'd0;
        state_d = StRun;
      end
    end else if (flushing) begin
      cd_d    = cd_q - 2'd1;
      state_d = (cd_q == 2'd1) ? StRun : StFlush;
    end else if (lu) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
      state_d     = StLdStall;
    end else begin
      state_d = StRun;
    end
  end

  always_comb begin
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b1;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b1;
    o_mem_wb_en   = 1'b1;
    o_fwd_a_sel   = fwd_sel(i_ex_rs1_addr, i_mem_rd_addr, i_mem_rd_wren,
                            i_wb_rd_addr, i_wb_rd_wren);
    o_fwd_b_sel   = fwd_sel(i_ex_rs2_addr, i_mem_rd_addr, i_mem_rd_wren,
                            i_wb_rd_addr, i_wb_rd_wren);
    if (i_reset) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      o_fwd_a_sel   = 2'b00;
      o_fwd_b_sel   = 2'b00;
    end else if (!i_dmem_ready) begin
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
    end else if (i_ex_mispredict) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (flushing) begin
      o_if_id_flush = 1'b1;
    end else if (lu) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
  end

  assign o_state     = state_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, all checked against a
// rule-level reference model of the pipeline controller.
module tb_hazard_ctrl;

  localparam int unsigned AW      = 5;
  localparam int unsigned CW      = 4;
  localparam int unsigned LAT     = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          i_clk;
  logic          i_reset;
  logic [AW-1:0] i_id_rs1_addr, i_id_rs2_addr;
  logic          i_id_rs1_used, i_id_rs2_used;
  logic [AW-1:0] i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr;
  logic          i_ex_rd_wren, i_ex_is_load;
  logic [AW-1:0] i_mem_rd_addr, i_wb_rd_addr;
  logic          i_mem_rd_wren, i_wb_rd_wren;
  logic          i_ex_mispredict, i_dmem_ready;
  logic          o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
  logic          o_ex_mem_en, o_mem_wb_en;
  logic [1:0]    o_fwd_a_sel, o_fwd_b_sel, o_state;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase (0 run,1 after stall,2 recovering,3 frozen), recovery cycles left.
  int m_state = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_ctrl #(
    .REG_ADDR_W(AW),
    .CNT_W     (CW),
    .IMEM_LAT  (LAT)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_id_rs1_addr  (i_id_rs1_addr),
    .i_id_rs2_addr  (i_id_rs2_addr),
    .i_id_rs1_used  (i_id_rs1_used),
    .i_id_rs2_used  (i_id_rs2_used),
    .i_ex_rs1_addr  (i_ex_rs1_addr),
    .i_ex_rs2_addr  (i_ex_rs2_addr),
    .i_ex_rd_addr   (i_ex_rd_addr),
    .i_ex_rd_wren   (i_ex_rd_wren),
    .i_ex_is_load   (i_ex_is_load),
    .i_mem_rd_addr  (i_mem_rd_addr),
    .i_mem_rd_wren  (i_mem_rd_wren),
    .i_wb_rd_addr   (i_wb_rd_addr),
    .i_wb_rd_wren   (i_wb_rd_wren),
    .i_ex_mispredict(i_ex_mispredict),
    .i_dmem_ready   (i_dmem_ready),
    .o_pc_en        (o_pc_en),
    .o_if_id_en     (o_if_id_en),
    .o_if_id_flush  (o_if_id_flush),
    .o_id_ex_en     (o_id_ex_en),
    .o_id_ex_flush  (o_id_ex_flush),
    .o_ex_mem_en    (o_ex_mem_en),
    .o_mem_wb_en    (o_mem_wb_en),
    .o_fwd_a_sel    (o_fwd_a_sel),
    .o_fwd_b_sel    (o_fwd_b_sel),
    .o_state        (o_state),
    .o_stall_cnt    (o_stall_cnt),
    .o_flush_cnt    (o_flush_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_fwd(input int rs);
    int mem_rd = int'(i_mem_rd_addr);
    int wb_rd  = int'(i_wb_rd_addr);
    if (i_mem_rd_wren && mem_rd != 0 && mem_rd == rs) return 1;
    if (i_wb_rd_wren && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  function automatic bit ref_lu();
    int rd = int'(i_ex_rd_addr);
    if (m_left > 0) return 1'b0;
    return i_ex_is_load && i_ex_rd_wren && rd != 0 &&
           ((i_id_rs1_used && int'(i_id_rs1_addr) == rd) ||
            (i_id_rs2_used && int'(i_id_rs2_addr) == rd));
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Expected strobes: {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb}
  task automatic compare_all();
    bit [6:0] e;
    int fa, fb;
    fa = ref_fwd(int'(i_ex_rs1_addr));
    fb = ref_fwd(int'(i_ex_rs2_addr));
    if (i_reset) begin
      e = 7'b1111111; fa = 0; fb = 0;
    end else if (!i_dmem_ready) e = 7'b0000000;
    else if (i_ex_mispredict)   e = 7'b1111111;
    else if (m_left > 0)        e = 7'b1111011;
    else if (ref_lu())          e = 7'b0001111;
    else                        e = 7'b1101011;
    check("pc_en",       o_pc_en,       e[6]);
    check("if_id_en",    o_if_id_en,    e[5]);
    check("if_id_flush", o_if_id_flush, e[4]);
    check("id_ex_en",    o_id_ex_en,    e[3]);
    check("id_ex_flush", o_id_ex_flush, e[2]);
    check("ex_mem_en",   o_ex_mem_en,   e[1]);
    check("mem_wb_en",   o_mem_wb_en,   e[0]);
    check("fwd_a",       o_fwd_a_sel,   fa);
    check("fwd_b",       o_fwd_b_sel,   fb);
    check("state",       o_state,       m_state);
    check("stall_cnt",   o_stall_cnt,   m_stall);
    check("flush_cnt",   o_flush_cnt,   m_flush);
  endtask

  task automatic model_update();
    if (i_reset) begin
      m_state = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else if (!i_dmem_ready) begin
      m_state = 3;
    end else if (i_ex_mispredict) begin
      m_flush = sat(m_flush);
      m_left  = LAT;
      m_state = (LAT > 0) ? 2 : 0;
    end else if (m_left > 0) begin
      m_left  = m_left - 1;
      m_state = (m_left == 0) ? 0 : 2;
    end else if (ref_lu()) begin
      m_stall = sat(m_stall);
      m_state = 1;
    end else begin
      m_state = 0;
    end
  endtask

  task automatic do_check();
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    i_reset = 0; i_dmem_ready = 1; i_ex_mispredict = 0;
    i_id_rs1_addr = 0; i_id_rs2_addr = 0; i_id_rs1_used = 0; i_id_rs2_used = 0;
    i_ex_rs1_addr = 0; i_ex_rs2_addr = 0; i_ex_rd_addr = 0; i_ex_rd_wren = 0;
    i_ex_is_load = 0; i_mem_rd_addr = 0; i_mem_rd_wren = 0;
    i_wb_rd_addr = 0; i_wb_rd_wren = 0;
  endtask

  task automatic set_load_use();
    i_ex_is_load = 1; i_ex_rd_wren = 1; i_ex_rd_addr = 5;
    i_id_rs1_addr = 5; i_id_rs1_used = 1; i_id_rs2_addr = 2; i_id_rs2_used = 1;
  endtask

  initial begin
    clear_inputs();
    i_reset = 1;
    i_mem_rd_addr = 7; i_mem_rd_wren = 1; i_ex_rs1_addr = 7;
    advance();
    advance();
    do_check();
    check("rst_pc_en", o_pc_en, 1);
    check("rst_if_id_flush", o_if_id_flush, 1);
    check("rst_fwd_a", o_fwd_a_sel, 0);
    advance();

    // Load-use: lw x5 in EX, add x6,x5,x2 in ID
    clear_inputs();
    set_load_use();
    do_check();
    check("lu_pc_en", o_pc_en, 0);
    check("lu_id_ex_flush", o_id_ex_flush, 1);
    advance();
    clear_inputs();
    do_check();
    check("lu_state", o_state, 1);
    check("lu_stall_cnt", o_stall_cnt, 1);
    check("lu_one_cycle", o_pc_en, 1);
    advance();

    // Load to x0 is never a hazard
    i_ex_is_load = 1; i_ex_rd_wren = 1; i_ex_rd_addr = 0;
    i_id_rs1_addr = 0; i_id_rs1_used = 1;
    do_check();
    check("lu_x0_pc_en", o_pc_en, 1);
    advance();

    // Forwarding priority and x0
    clear_inputs();
    i_mem_rd_addr = 7; i_mem_rd_wren = 1; i_wb_rd_addr = 7; i_wb_rd_wren = 1;
    i_ex_rs1_addr = 7; i_ex_rs2_addr = 7;
    do_check();
    check("fwd_mem_a", o_fwd_a_sel, 1);
    check("fwd_mem_b", o_fwd_b_sel, 1);
    advance();
    i_mem_rd_wren = 0;
    do_check();
    check("fwd_wb_a", o_fwd_a_sel, 2);
    check("fwd_wb_b", o_fwd_b_sel, 2);
    advance();
    i_mem_rd_wren = 1; i_mem_rd_addr = 0; i_ex_rs1_addr = 0; i_wb_rd_wren = 0;
    do_check();
    check("fwd_x0_a", o_fwd_a_sel, 0);
    advance();

    // Mispredict with two extra IMEM cycles
    clear_inputs();
    i_ex_mispredict = 1;
    do_check();
    check("mp_if_id_flush", o_if_id_flush, 1);
    check("mp_id_ex_flush", o_id_ex_flush, 1);
    advance();
    i_ex_mispredict = 0;
    for (int i = 0; i < 2; i++) begin
      do_check();
      check("mp_rec_state", o_state, 2);
      check("mp_rec_if_id_flush", o_if_id_flush, 1);
      advance();
    end
    do_check();
    check("mp_done_state", o_state, 0);
    check("mp_flush_cnt", o_flush_cnt, 1);
    advance();

    // Mispredict overrides a simultaneous load-use
    set_load_use();
    i_ex_mispredict = 1;
    do_check();
    check("mplu_pc_en", o_pc_en, 1);
    advance();
    clear_inputs();
    do_check();
    check("mplu_stall_cnt", o_stall_cnt, 1);
    check("mplu_flush_cnt", o_flush_cnt, 2);
    advance();
    do_check();
    advance();

    // Freeze during recovery holds the countdown
    i_ex_mispredict = 1;
    do_check();
    advance();
    i_ex_mispredict = 0; i_dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      do_check();
      check("frz_pc_en", o_pc_en, 0);
      check("frz_mem_wb_en", o_mem_wb_en, 0);
      advance();
    end
    i_dmem_ready = 1;
    do_check();
    check("frz_resume_state", o_state, 3);
    check("frz_resume_if_id_flush", o_if_id_flush, 1);
    advance();
    do_check();
    check("frz_resume2_state", o_state, 2);
    check("frz_resume2_if_id_flush", o_if_id_flush, 1);
    advance();
    do_check();
    check("frz_done_state", o_state, 0);
    advance();

    // Reset in the middle of recovery
    i_ex_mispredict = 1;
    do_check();
    advance();
    i_ex_mispredict = 0; i_reset = 1;
    do_check();
    advance();
    i_reset = 0;
    do_check();
    check("rstmid_state", o_state, 0);
    check("rstmid_flush_cnt", o_flush_cnt, 0);
    advance();

    // Random traffic; small address range makes matches and counter saturation common
    for (int n = 0; n < 3000; n++) begin
      i_reset         = ($urandom_range(0, 99) == 0);
      i_dmem_ready    = ($urandom_range(0, 5) != 0);
      i_ex_mispredict = ($urandom_range(0, 9) == 0);
      i_id_rs1_addr   = AW'($urandom_range(0, 3));
      i_id_rs2_addr   = AW'($urandom_range(0, 3));
      i_id_rs1_used   = 1'($urandom_range(0, 1));
      i_id_rs2_used   = 1'($urandom_range(0, 1));
      i_ex_rs1_addr   = AW'($urandom_range(0, 3));
      i_ex_rs2_addr   = AW'($urandom_range(0, 3));
      i_ex_rd_addr    = AW'($urandom_range(0, 3));
      i_ex_rd_wren    = 1'($urandom_range(0, 1));
      i_ex_is_load    = 1'($urandom_range(0, 1));
      i_mem_rd_addr   = AW'($urandom_range(0, 3));
      i_mem_rd_wren   = 1'($urandom_range(0, 1));
      i_wb_rd_addr    = AW'($urandom_range(0, 3));
      i_wb_rd_wren    = 1'($urandom_range(0, 1));
      do_check();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
